// File: rtl/wb_crc32.sv
// wb_crc32: Wishbone B4 pipelined slave computing reflected CRC-32
// (poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over data bytes
// written by the bus master. A bit-serial engine processes BITS_PER_CYCLE
// bits per clock and the slave stalls the bus while the engine is busy.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cyc, stb, we     Wishbone cycle, strobe, write enable
//   sel[3:0]         byte lane selects (DATA writes only)
//   adr[AW-1:0]      byte address, only adr[3:2] decoded
//   dat_i[31:0]      write data
//   dat_o[31:0]      read data, valid in the ack cycle, 0 otherwise
//   ack, err         response one cycle after acceptance, gated by cyc
//   stall            pipeline stall
//   busy             engine active; also exposes the FSM state (SHIFT)
//
// Handshake: a request is accepted on a rising edge where cyc & stb & !stall.
// The response (ack or err) appears the following cycle for exactly one
// cycle, and is dropped if the master has released cyc by then.
//
// Register map (adr[3:2]): 0 CTRL (W, bit0 reloads crc), 1 DATA (W),
// 2 RESULT (R, ~crc), 3 STATUS (R, bit0 = busy).
module wb_crc32 #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int AW             = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cyc,
  input  logic          stb,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   dat_i,
  output logic [31:0]   dat_o,
  output logic          ack,
  output logic          stall,
  output logic          err,
  output logic          busy
);

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [2:0]  BIT_INC  = 3'(BITS_PER_CYCLE % 8);
  localparam logic [2:0]  LAST_BIT = 3'(8 - BITS_PER_CYCLE);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_nxt;
  logic [31:0] shreg_q;
  logic [3:0]  mask_q, mask_next;
  logic [2:0]  bit_cnt_q;
  logic [31:0] rdata_q;
  logic        ack_pend_q, err_pend_q;

  logic [1:0]  reg_idx;
  logic        accept, wr_data, start, bad_sel, byte_done, ctrl_init;
  logic [1:0]  lane;
  logic [7:0]  cur_byte;

  logic        unused_adr;
  assign unused_adr = ^{adr[AW-1:4], adr[1:0]};

  assign reg_idx   = adr[3:2];
  assign busy      = (state_q == SHIFT);
  // STATUS reads pass through while busy so firmware can poll.
  assign stall     = busy & cyc & stb & ~(~we & (reg_idx == 2'd3));
  assign accept    = cyc & stb & ~stall;
  assign wr_data   = accept & we & (reg_idx == 2'd1);
  assign start     = wr_data & (sel != 4'b0000);
  assign bad_sel   = wr_data & (sel == 4'b0000);
  assign ctrl_init = accept & we & (reg_idx == 2'd0) & dat_i[0];
  assign byte_done = (bit_cnt_q == LAST_BIT);

  // mask_q holds the lanes still to be processed; the current lane is the
  // lowest set bit, and clearing it advances to the next lane upward.
  assign mask_next = mask_q & (mask_q - 4'd1);

  always_comb begin
    lane = 2'd3;
    if (mask_q[0])      lane = 2'd0;
    else if (mask_q[1]) lane = 2'd1;
    else if (mask_q[2]) lane = 2'd2;
  end

  assign cur_byte = shreg_q[{lane, 3'b000} +: 8];

  // BITS_PER_CYCLE serial CRC steps, LSB of the byte first.
  always_comb begin
    logic [2:0] bit_idx;
    logic       fb;
    bit_idx = 3'd0;
    fb      = 1'b0;
    crc_nxt = crc_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      bit_idx = bit_cnt_q + 3'(i);
      fb      = crc_nxt[0] ^ cur_byte[bit_idx];
      crc_nxt = (crc_nxt >> 1) ^ (fb ? POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: if (byte_done && (mask_next == 4'b0000)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= 32'hFFFFFFFF;
      shreg_q   <= 32'h0;
      mask_q    <= 4'b0000;
      bit_cnt_q <= 3'd0;
    end else begin
      if (start) begin
        shreg_q   <= dat_i;
        mask_q    <= sel;
        bit_cnt_q <= 3'd0;
      end else if (state_q == SHIFT) begin
        crc_q <= crc_nxt;
        if (byte_done) begin
          bit_cnt_q <= 3'd0;
          mask_q    <= mask_next;
        end else begin
          bit_cnt_q <= bit_cnt_q + BIT_INC;
        end
      end
      // Only reachable in IDLE: CTRL writes are stalled while shifting.
      if (ctrl_init) crc_q <= 32'hFFFFFFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      ack_pend_q <= accept & ~bad_sel;
      err_pend_q <= bad_sel;
      rdata_q    <= 32'h0;
      if (accept && !we) begin
        case (reg_idx)
          2'd2:    rdata_q <= ~crc_q;
          2'd3:    rdata_q <= {31'h0, busy};
          default: rdata_q <= 32'h0;
        endcase
      end
    end
  end

  assign ack   = ack_pend_q & cyc;
  assign err   = err_pend_q & cyc;
  assign dat_o = ack ? rdata_q : 32'h0;

endmodule

// File: tb/tb_wb_crc32.sv
// Testbench for wb_crc32: four instances (BITS_PER_CYCLE = 1, 2, 4, 8) on
// separate buses. Driver tasks push the expected response of every issued
// request into exp_q; a monitor pops and compares on each ack/err.
module tb_wb_crc32;

  localparam int NI = 4;

  logic        clk;
  logic        rst_n;
  logic        cyc_a   [NI];
  logic        stb_a   [NI];
  logic        we_a    [NI];
  logic [3:0]  sel_a   [NI];
  logic [31:0] adr_a   [NI];
  logic [31:0] dat_i_a [NI];
  logic [31:0] dat_o_a [NI];
  logic        ack_a   [NI];
  logic        stall_a [NI];
  logic        err_a   [NI];
  logic        busy_a  [NI];

  logic [32:0] exp_q[$];   // {err, dat_o}
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_crc32 #(.BITS_PER_CYCLE(1 << g), .AW(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cyc   (cyc_a[g]),
      .stb   (stb_a[g]),
      .we    (we_a[g]),
      .sel   (sel_a[g]),
      .adr   (adr_a[g]),
      .dat_i (dat_i_a[g]),
      .dat_o (dat_o_a[g]),
      .ack   (ack_a[g]),
      .stall (stall_a[g]),
      .err   (err_a[g]),
      .busy  (busy_a[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ack_a[k] === 1'b1 || err_a[k] === 1'b1) begin
        logic [32:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d: ack=%0b err=%0b dat=0x%08h, none expected",
                   k, ack_a[k], err_a[k], dat_o_a[k]);
        end else begin
          e = exp_q.pop_front();
          if (ack_a[k] === err_a[k] || {err_a[k], dat_o_a[k]} !== e) begin
            errors++;
            $display("FAIL resp dut%0d: ack=%0b err=%0b dat=0x%08h expected err=%0b dat=0x%08h",
                     k, ack_a[k], err_a[k], dat_o_a[k], e[32], e[31:0]);
          end
        end
      end
    end
  end

  // driver tasks: each is entered and left one time step after a rising edge
  task automatic issue(input int k, input logic w, input logic [1:0] ri, input logic [3:0] s,
                       input logic [31:0] d, input logic resp, input logic [32:0] expv,
                       output int stalls);
    logic [31:0] junk;
    junk       = $urandom();
    cyc_a[k]   = 1'b1;
    stb_a[k]   = 1'b1;
    we_a[k]    = w;
    sel_a[k]   = s;
    adr_a[k]   = {junk[31:4], ri, junk[1:0]};
    dat_i_a[k] = d;
    stalls     = 0;
    @(negedge clk);
    while (stall_a[k] === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      errors++;
      $display("FAIL stall_timeout dut%0d: stalled %0d cycles, limit 200", k, stalls);
    end else if (resp) begin
      exp_q.push_back(expv);
    end
    @(posedge clk); #1;
    stb_a[k] = 1'b0;
    we_a[k]  = 1'b0;
  endtask

  task automatic wr(input int k, input logic [1:0] ri, input logic [3:0] s, input logic [31:0] d);
    int st;
    issue(k, 1'b1, ri, s, d, 1'b1, 33'h0, st);
  endtask

  task automatic rd(input int k, input logic [1:0] ri, input logic [31:0] expd);
    int st;
    issue(k, 1'b0, ri, 4'h0, 32'h0, 1'b1, {1'b0, expd}, st);
  endtask

  task automatic wait_idle(input int k, output int n);
    n = 0;
    @(negedge clk);
    while (busy_a[k] === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL busy_timeout dut%0d: busy did not fall", k);
    end
    @(posedge clk); #1;
  endtask

  task automatic bus_idle(input int k);
    @(posedge clk); #1;
    cyc_a[k] = 1'b0;
  endtask

  // "123456789" in three words, busy length checked per word
  task automatic check_value(input int k);
    int n;
    int bpc;
    bpc = 1 << k;
    wr(k, 2'd0, 4'hF, 32'h1);
    wr(k, 2'd1, 4'hF, 32'h34333231);
    wait_idle(k, n);
    chk($sformatf("busy_word1_bpc%0d", bpc), n, 32 / bpc);
    wr(k, 2'd1, 4'hF, 32'h38373635);
    wait_idle(k, n);
    chk($sformatf("busy_word2_bpc%0d", bpc), n, 32 / bpc);
    wr(k, 2'd1, 4'h1, 32'h00000039);
    wait_idle(k, n);
    chk($sformatf("busy_byte_bpc%0d", bpc), n, 8 / bpc);
    rd(k, 2'd2, 32'hCBF43926);
    bus_idle(k);
  endtask

  initial begin
    int n;
    int st;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      cyc_a[k] = 0; stb_a[k] = 0; we_a[k] = 0;
      sel_a[k] = 0; adr_a[k] = 0; dat_i_a[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_busy",  {31'h0, busy_a[0]},  32'h0);
    chk("rst_stall", {31'h0, stall_a[0]}, 32'h0);
    chk("rst_ack",   {31'h0, ack_a[0]},   32'h0);
    chk("rst_err",   {31'h0, err_a[0]},   32'h0);
    chk("rst_dat_o", dat_o_a[0],          32'h0);
    @(posedge clk); #1;
    rd(0, 2'd2, 32'h0);
    rd(0, 2'd3, 32'h0);
    bus_idle(0);

    // check value, BITS_PER_CYCLE = 1
    check_value(0);

    // empty message after init
    wr(0, 2'd0, 4'hF, 32'h1);
    rd(0, 2'd2, 32'h00000000);

    // single lane 2 byte equals byte 0x31 alone
    wr(0, 2'd0, 4'hF, 32'h1);
    wr(0, 2'd1, 4'b0100, 32'h00310000);
    wait_idle(0, n);
    chk("busy_lane2", n, 8);
    rd(0, 2'd2, 32'h83DCEFB7);

    // no-op CTRL, ignored RESULT/STATUS writes, zero reads of write-only regs
    wr(0, 2'd0, 4'hF, 32'h2);
    wr(0, 2'd2, 4'hF, 32'hFFFFFFFF);
    wr(0, 2'd3, 4'hF, 32'hFFFFFFFF);
    rd(0, 2'd2, 32'h83DCEFB7);
    rd(0, 2'd0, 32'h0);
    rd(0, 2'd1, 32'h0);

    // DATA with sel = 0 -> err, engine stays idle
    issue(0, 1'b1, 2'd1, 4'b0000, 32'h12345678, 1'b1, {1'b1, 32'h0}, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_no_busy", {31'h0, busy_a[0]}, 32'h0);
    end
    @(posedge clk); #1;
    rd(0, 2'd2, 32'h83DCEFB7);
    bus_idle(0);

    // pipelined pair: last word then RESULT read stalled for the whole word
    wr(0, 2'd0, 4'hF, 32'h1);
    wr(0, 2'd1, 4'hF, 32'h34333231);
    wait_idle(0, n);
    wr(0, 2'd1, 4'h1, 32'h00000035);
    wait_idle(0, n);
    wr(0, 2'd1, 4'hF, 32'h39383736);
    issue(0, 1'b0, 2'd2, 4'h0, 32'h0, 1'b1, {1'b0, 32'hCBF43926}, st);
    chk("pipelined_stall_cycles", st, 32);
    bus_idle(0);

    // cyc dropped in the ack cycle: no ack, engine still finishes the word
    wr(0, 2'd0, 4'hF, 32'h1);
    issue(0, 1'b1, 2'd1, 4'hF, 32'h34333231, 1'b0, 33'h0, st);
    cyc_a[0] = 1'b0;
    wait_idle(0, n);
    chk("cyc_abort_busy", n, 32);
    wr(0, 2'd1, 4'hF, 32'h38373635);
    // STATUS read while busy is not stalled and returns 1
    issue(0, 1'b0, 2'd3, 4'h0, 32'h0, 1'b1, {1'b0, 32'h1}, st);
    chk("status_no_stall", st, 0);
    wait_idle(0, n);
    wr(0, 2'd1, 4'h1, 32'h00000039);
    rd(0, 2'd2, 32'hCBF43926);
    bus_idle(0);

    // reset in the middle of a word with a stalled read outstanding
    wr(0, 2'd0, 4'hF, 32'h1);
    wr(0, 2'd1, 4'hF, 32'h34333231);
    stb_a[0] = 1'b1;
    we_a[0]  = 1'b0;
    adr_a[0] = 32'h8;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy",  {31'h0, busy_a[0]},  32'h0);
    chk("rst_mid_stall", {31'h0, stall_a[0]}, 32'h0);
    chk("rst_mid_ack",   {31'h0, ack_a[0]},   32'h0);
    stb_a[0] = 1'b0;
    cyc_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 1'b0, 2'd2, 4'h0, 32'h0, 1'b1, {1'b0, 32'h00000000}, st);
    chk("post_rst_no_stall", st, 0);
    bus_idle(0);

    // parameter sweep
    for (int k = 1; k < NI; k++) check_value(k);

    repeat (3) @(posedge clk);
    chk("pending_responses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
